pwl_stim_seq: RTL and testbench

PWL_STIM_SEQ -- requirements
Module: pwl_stim_seq

---
 rtl/pwl_pkg.sv | 20 ++
 rtl/pwl_seg_table.sv | 39 +++
 rtl/pwl_stim_seq.sv | 157 +++++++++++++++
 tb/tb_pwl_stim_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwl_pkg.sv
// Shared types and default sizes for the piecewise-linear stimulus sequencer.
package pwl_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_VW    = 16;
  localparam int DEF_CW    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pwl_state_e;

  // One table entry: amplitude code and how many accepted samples it lasts.
  typedef struct packed {
    logic signed [DEF_VW-1:0] val;
    logic        [DEF_CW-1:0] dur;
  } pwl_seg_t;

endpackage

// File: rtl/pwl_seg_table.sv
// Segment register file: one synchronous write port, one asynchronous read port.
module pwl_seg_table
  import pwl_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int VW    = DEF_VW,
  parameter int CW    = DEF_CW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wrEn,
  input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
  input  logic [VW-1:0]            i_wrVal,
  input  logic [CW-1:0]            i_wrDur,
  input  logic [$clog2(DEPTH)-1:0] i_rdIdx,
  output logic [VW-1:0]            o_rdVal,
  output logic [CW-1:0]            o_rdDur
);

  logic [VW-1:0] r_val [DEPTH];
  logic [CW-1:0] r_dur [DEPTH];

  // Every entry clears on reset so a fresh run always starts from known data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_val[i] <= '0;
        r_dur[i] <= '0;
      end
    end else if (i_wrEn) begin
      r_val[i_wrAddr] <= i_wrVal;
      r_dur[i_wrAddr] <= i_wrDur;
    end
  end

  assign o_rdVal = r_val[i_rdIdx];
  assign o_rdDur = r_dur[i_rdIdx];

endmodule

// File: rtl/pwl_stim_seq.sv
// Piecewise-constant stimulus sequencer: walks a segment table and streams
// amplitude codes downstream over a valid/ready handshake.
module pwl_stim_seq
  import pwl_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int VW    = DEF_VW,
  parameter int CW    = DEF_CW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [VW-1:0]            wr_val,
  input  logic [CW-1:0]            wr_dur,
  input  logic [$clog2(DEPTH):0]   nseg,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic [VW-1:0]            out_val,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);

  pwl_state_e      r_state, w_nState;
  logic [AW-1:0]   r_seg, w_nSeg;
  logic [CW-1:0]   r_cnt, w_nCnt;
  logic [AW:0]     r_nseg, w_nNseg;
  logic            r_loop, w_nLoop;
  logic [VW-1:0]   r_holdVal, w_nHold;

  logic [VW-1:0]   w_rdVal;
  logic [CW-1:0]   w_rdDur;
  logic [CW-1:0]   w_cntMax;
  logic [AW:0]     w_nsegClamped;
  logic            w_tblWrEn;
  logic            w_xfer;
  logic            w_lastCnt;
  logic            w_lastSeg;
  logic            w_startOk;

  assign w_tblWrEn = wr_en && (r_state != RUN);

  pwl_seg_table #(
    .DEPTH (DEPTH),
    .VW    (VW),
    .CW    (CW)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wrEn   (w_tblWrEn),
    .i_wrAddr (wr_addr),
    .i_wrVal  (wr_val),
    .i_wrDur  (wr_dur),
    .i_rdIdx  (r_seg),
    .o_rdVal  (w_rdVal),
    .o_rdDur  (w_rdDur)
  );

  // A zero duration is treated as one sample so every segment is emitted.
  assign w_cntMax      = (w_rdDur == '0) ? '0 : (w_rdDur - CW'(1));
  assign w_lastCnt     = (r_cnt == w_cntMax);
  assign w_lastSeg     = (({1'b0, r_seg} + (AW+1)'(1)) == r_nseg);
  assign w_xfer        = (r_state == RUN) && out_ready;
  assign w_startOk     = start && !stop && (nseg != '0);
  assign w_nsegClamped = (nseg > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : nseg;

  always_comb begin
    w_nState = r_state;
    w_nSeg   = r_seg;
    w_nCnt   = r_cnt;
    w_nNseg  = r_nseg;
    w_nLoop  = r_loop;
    w_nHold  = r_holdVal;
    unique case (r_state)
      IDLE: begin
        if (w_startOk) begin
          w_nState = RUN;
          w_nSeg   = '0;
          w_nCnt   = '0;
          w_nNseg  = w_nsegClamped;
          w_nLoop  = loop;
        end
      end
      RUN: begin
        if (stop) begin
          w_nState = IDLE;
          w_nSeg   = '0;
          w_nCnt   = '0;
          w_nHold  = '0;
        end else if (w_xfer) begin
          if (w_lastCnt) begin
            w_nCnt = '0;
            if (w_lastSeg) begin
              if (r_loop) begin
                w_nSeg = '0;
              end else begin
                w_nState = DONE;
                w_nHold  = w_rdVal;
              end
            end else begin
              w_nSeg = r_seg + AW'(1);
            end
          end else begin
            w_nCnt = r_cnt + CW'(1);
          end
        end
      end
      DONE: begin
        if (stop) begin
          w_nState = IDLE;
          w_nSeg   = '0;
          w_nCnt   = '0;
          w_nHold  = '0;
        end else if (w_startOk) begin
          w_nState = RUN;
          w_nSeg   = '0;
          w_nCnt   = '0;
          w_nNseg  = w_nsegClamped;
          w_nLoop  = loop;
        end
      end
      default: begin
        w_nState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_seg     <= '0;
      r_cnt     <= '0;
      r_nseg    <= '0;
      r_loop    <= 1'b0;
      r_holdVal <= '0;
    end else begin
      r_state   <= w_nState;
      r_seg     <= w_nSeg;
      r_cnt     <= w_nCnt;
      r_nseg    <= w_nNseg;
      r_loop    <= w_nLoop;
      r_holdVal <= w_nHold;
    end
  end

  // Writes are blocked in RUN, so the entry under r_seg is stable while offered.
  assign out_val   = (r_state == RUN) ? w_rdVal : r_holdVal;
  assign out_valid = (r_state == RUN);
  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_pwl_stim_seq.sv
// Directed self-checking bench for pwl_stim_seq with hand-computed expectations.
module tb_pwl_stim_seq;
  import pwl_pkg::*;

  localparam int DEPTH = 8;
  localparam int VW    = 16;
  localparam int CW    = 16;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [VW-1:0] wr_val;
  logic [CW-1:0] wr_dur;
  logic [AW:0]   nseg;
  logic          loop;
  logic          start;
  logic          stop;
  logic [VW-1:0] out_val;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int vecCount  = 0;
  int missCount = 0;

  pwl_stim_seq #(.DEPTH(DEPTH), .VW(VW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_val    (wr_val),
    .wr_dur    (wr_dur),
    .nseg      (nseg),
    .loop      (loop),
    .start     (start),
    .stop      (stop),
    .out_val   (out_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic int sv(input logic [VW-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeEntry(input int addr, input pwl_seg_t seg);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_val  = seg.val;
    wr_dur  = seg.dur;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input logic lp);
    nseg  = (AW+1)'(n);
    loop  = lp;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulseStop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  int expSeq[6] = '{5, 5, -3, 7, 7, 7};
  int xfers;
  int stalls;
  int validCycles;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_val = '0; wr_dur = '0;
    nseg = '0; loop = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
    #1;
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_val",   sv(out_val), 0);
    checkOutput("rst_busy",  int'(busy), 0);
    checkOutput("rst_done",  int'(done), 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Basic three-segment run
    writeEntry(0, '{val: 16'sd5,  dur: 16'd2});
    writeEntry(1, '{val: -16'sd3, dur: 16'd1});
    writeEntry(2, '{val: 16'sd7,  dur: 16'd3});
    applyStimulus(3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("t1_valid%0d", i), int'(out_valid), 1);
      checkOutput($sformatf("t1_val%0d", i), sv(out_val), expSeq[i]);
      step();
    end
    checkOutput("t1_done",  int'(done), 1);
    checkOutput("t1_valid", int'(out_valid), 0);
    checkOutput("t1_hold",  sv(out_val), 7);
    checkOutput("t1_busy",  int'(busy), 0);

    // Same table with a four-cycle stall on the second sample
    applyStimulus(3, 1'b0);
    xfers  = 0;
    stalls = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      out_ready = !(xfers == 1 && stalls < 4);
      if (out_valid) begin
        if (xfers < 6) begin
          checkOutput($sformatf("t2_val%0d", c), sv(out_val), expSeq[xfers]);
        end else begin
          checkOutput($sformatf("t2_extra%0d", c), int'(out_valid), 0);
        end
        if (out_ready) xfers++;
        else stalls++;
      end
      step();
    end
    out_ready = 1'b1;
    checkOutput("t2_xfers",  xfers, 6);
    checkOutput("t2_stalls", stalls, 4);
    checkOutput("t2_done",   int'(done), 1);
    checkOutput("t2_hold",   sv(out_val), 7);

    // Looping two-segment table, start ignored mid-run, then stop
    writeEntry(0, '{val: 16'sd1, dur: 16'd1});
    writeEntry(1, '{val: 16'sd2, dur: 16'd1});
    applyStimulus(2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t3_val%0d", i), sv(out_val), (i % 2 == 0) ? 1 : 2);
      if (i == 4) begin
        nseg  = 4'd1;
        start = 1'b1;
      end
      step();
      start = 1'b0;
    end
    checkOutput("t3_busy", int'(busy), 1);
    pulseStop();
    checkOutput("t3_stop_valid", int'(out_valid), 0);
    checkOutput("t3_stop_val",   sv(out_val), 0);
    checkOutput("t3_stop_busy",  int'(busy), 0);
    checkOutput("t3_stop_done",  int'(done), 0);

    // nseg of zero must not launch a run
    applyStimulus(0, 1'b0);
    checkOutput("t_nseg0_busy", int'(busy), 0);

    // Zero duration acts as one sample
    writeEntry(0, '{val: 16'sd9, dur: 16'd0});
    applyStimulus(1, 1'b0);
    checkOutput("t4_valid", int'(out_valid), 1);
    checkOutput("t4_val",   sv(out_val), 9);
    step();
    checkOutput("t4_done",  int'(done), 1);
    checkOutput("t4_valid_after", int'(out_valid), 0);
    checkOutput("t4_hold",  sv(out_val), 9);

    // Simultaneous start and stop in DONE: stop wins
    nseg  = 4'd1;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("t_ss_busy", int'(busy), 0);
    checkOutput("t_ss_done", int'(done), 0);
    checkOutput("t_ss_val",  sv(out_val), 0);

    // Writes during RUN are dropped
    writeEntry(0, '{val: 16'sd4, dur: 16'd3});
    applyStimulus(1, 1'b1);
    checkOutput("t5_val_pre", sv(out_val), 4);
    writeEntry(0, '{val: 16'sd100, dur: 16'd1});
    checkOutput("t5_val_post", sv(out_val), 4);
    pulseStop();
    applyStimulus(1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t5_rerun%0d", i), sv(out_val), 4);
      step();
    end
    checkOutput("t5_done", int'(done), 1);

    // Async reset mid-run clears the table and outputs
    applyStimulus(1, 1'b1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_valid", int'(out_valid), 0);
    checkOutput("t6_val",   sv(out_val), 0);
    checkOutput("t6_busy",  int'(busy), 0);
    checkOutput("t6_done",  int'(done), 0);
    step();
    rst_n = 1'b1;
    step();
    applyStimulus(1, 1'b0);
    checkOutput("t6_run_valid", int'(out_valid), 1);
    checkOutput("t6_run_val",   sv(out_val), 0);
    step();
    checkOutput("t6_run_done",  int'(done), 1);

    // Oversized nseg clamps to DEPTH; cleared entries last one sample each
    applyStimulus(15, 1'b0);
    validCycles = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (out_valid) validCycles++;
      step();
    end
    checkOutput("t7_clamp_count", validCycles, DEPTH);
    checkOutput("t7_done", int'(done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
